vmem_sched: RTL and testbench
=============================

# vmem_sched

Scheduler for the single-port video memory shared between VGA scan-out and two pixel writers: a buffered CPU write port and a built-in screen-fill engine. It sits between `vga_ctrl`, the video memory and the CPU-side pixel bus. It gives scan-out absolute priority during the visible region and grants write slots otherwise. Pixel address is `{v[8:0], h[9:0]}`. The memory reads combinationally and writes synchronously on the `clk` rising edge.

## Interface
- `FIFO_DEPTH`, 4, CPU write buffer depth; power of two, ≥2
- `H_ACTIVE`, 640, visible width; writes with h ≥ this are dropped
- `V_ACTIVE`, 480, visible height; writes with v ≥ this are dropped

- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-low reset
- `disp_valid`  in  1  visible-region flag from `vga_ctrl`
- `disp_h` / `disp_v`  in  10 / 10  scan-out pixel coordinates
- `vga_data`  out  24  pixel to `vga_ctrl`
- `wr_valid`  in  1  CPU write request
- `wr_ready`  out  1  FIFO can accept a request
- `wr_h` / `wr_v`  in  10 / 10  CPU write coordinates
- `wr_data`  in  24  CPU write colour
- `wr_drop`  out  1  1-cycle pulse: popped entry was out of range
- `fill_start`  in  1  pulse: start full-screen fill
- `fill_color`  in  24  fill colour, sampled on accepted `fill_start`
- `fill_busy`  out  1  fill in progress
- `fill_done`  out  1  1-cycle pulse when the fill completes
- `mem_addr`  out  19  memory address
- `mem_we`  out  1  memory write enable
- `mem_wdata`  out  24  memory write data
- `mem_rdata`  in  24  memory read data (combinational)

## Operation
- **Display path:**
  - `disp_valid`=1: `mem_addr`={disp_v[8:0],disp_h}, `mem_we`=0, `vga_data`=`mem_rdata`. No write slot that cycle.
  - `disp_valid`=0: `vga_data`=0 and the cycle is a write slot.
- **CPU FIFO:**
  - A push happens on `wr_valid & wr_ready`. `wr_ready` = !full.
  - A pop happens when the FIFO wins a write slot.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Entry with h ≥ H_ACTIVE or v ≥ V_ACTIVE: it is popped in a write slot with `mem_we`=0 and `wr_drop`=1. It still counts as a FIFO grant.
- **Fill engine FSM:**
  - States: IDLE and FILL.
  - IDLE→FILL on `fill_start`. This latches `fill_color` and sets the cursor to (0,0).
  - Each granted slot writes the cursor pixel.
  - h increments and wraps at H_ACTIVE-1 to 0, with v+1.
  - After the write at (H_ACTIVE-1, V_ACTIVE-1) the FSM goes to IDLE and pulses `fill_done`.
  - `fill_start` in FILL is ignored.
- **Slot arbitration:**
  - A write slot goes to the FIFO if only it is non-empty, and to the fill engine if only it is in FILL.
  - If both request, round-robin against the last winner. After reset the FIFO wins first.
  - A slot with no requester leaves `mem_we`=0.
- **Write path:** `mem_addr`, `mem_wdata` and `mem_we` are driven combinationally from the winner. The memory commits at the closing edge.

## Timing
- **Reset values:** FIFO empty, `wr_ready`=1, `mem_we`=0, `wr_drop`=0, `fill_busy`=0, `fill_done`=0, arbiter pointer = FIFO.
  - Reset mid-fill aborts the fill with no `fill_done`.
  - Reset discards FIFO contents.
- **CPU write latency:** push at cycle N gives an earliest `mem_we` in cycle N+1, with the memory updated at the end of N+1.
- **Fill timing:**
  - `fill_busy` rises the cycle after an accepted `fill_start`.
  - It falls in the cycle after the final write; `fill_done` pulses in that same cycle.
- **Minimum fill duration:** H_ACTIVE×V_ACTIVE blank cycles when uncontended.
- **Visible region:** no write ever occurs while `disp_valid`=1. Queued writes simply wait.

## Configuration
- `VMEM_SCHED_FILL_EN` defined: the fill engine and round-robin arbitration are built.
- Undefined:
  - Fill logic is removed. `fill_start` and `fill_color` are ignored, and `fill_busy`/`fill_done` are tied to 0.
  - Every write slot goes to the FIFO.

## Test plan
- **Reset:** hold `rst`=0 → `wr_ready`=1, `mem_we`=0, `fill_busy`=0, `vga_data`=0. Release and confirm no spurious write.
- **Blanking write:** with `disp_valid`=0, push (h=5, v=3, 0x00FF00) → next cycle `mem_we`=1, `mem_addr`=0x00C05, `mem_wdata`=0x00FF00.
- **Backpressure and ordering:**
  - With `disp_valid`=1, push 4 writes → `wr_ready`=0 after the 4th; `mem_we` stays 0; `vga_data` tracks `mem_rdata`.
  - Drop `disp_valid` → the 4 writes drain in order on consecutive cycles.
- **Out-of-range drop:** push h=640 → on pop, `wr_drop`=1 and `mem_we`=0.
- **Fill (FILL_EN):**
  - Use a small model with H_ACTIVE=4, V_ACTIVE=2 and `fill_color`=0x123456 → 8 writes to addresses 0,1,2,3,0x400…0x403, then `fill_done` pulses once.
  - A second `fill_start` mid-fill has no effect.
- **Contention (FILL_EN):** FIFO non-empty while filling → grants alternate FIFO, fill, FIFO, …; abort with a mid-fill reset → `fill_busy`=0 with no `fill_done`.

Source files
------------

// File: rtl/vmem_sched.sv
// vmem_sched: video memory slot scheduler.
// Scan-out owns the single memory port whenever disp_valid is high. Every
// blanking cycle is a write slot, granted to the buffered CPU write FIFO or
// to the screen-fill engine.
// Optional feature macro: VMEM_SCHED_FILL_EN builds the fill engine and the
// round-robin arbiter; without it every write slot goes to the CPU FIFO.
`timescale 1ns/1ps

module vmem_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        disp_valid,
  input  logic [9:0]  disp_h,
  input  logic [9:0]  disp_v,
  output logic [23:0] vga_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [9:0]  wr_h,
  input  logic [9:0]  wr_v,
  input  logic [23:0] wr_data,
  output logic        wr_drop,
  input  logic        fill_start,
  input  logic [23:0] fill_color,
  output logic        fill_busy,
  output logic        fill_done,
  output logic [18:0] mem_addr,
  output logic        mem_we,
  output logic [23:0] mem_wdata,
  input  logic [23:0] mem_rdata
);

  localparam int         AW     = $clog2(FIFO_DEPTH);
  localparam logic [9:0] H_LIM  = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM  = 10'(V_ACTIVE);

  typedef struct packed {
    logic [9:0]  v;
    logic [9:0]  h;
    logic [23:0] data;
  } wr_entry_t;

  // CPU write FIFO state
  wr_entry_t         fifo_q [FIFO_DEPTH];
  wr_entry_t         fifo_d [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       count_q, count_d;

  wr_entry_t         head;
  logic              head_oor;
  logic              push;
  logic              pop;

  // Arbitration results shared by both build variants
  logic              grant_fifo;
  logic              grant_fill;
  logic [18:0]       fill_addr;
  logic [23:0]       fill_wdata;

  assign wr_ready = (count_q != (AW+1)'(FIFO_DEPTH));
  assign push     = wr_valid & wr_ready;
  assign pop      = grant_fifo;
  assign head     = fifo_q[rd_ptr_q];
  assign head_oor = (head.h >= H_LIM) || (head.v >= V_LIM);

  // FIFO next state: write at the tail on push, advance the head on pop
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{v: wr_v, h: wr_h, data: wr_data};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // FIFO registers; reset discards any queued writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef VMEM_SCHED_FILL_EN

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0] V_LAST = 9'(V_ACTIVE - 1);

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  state_t       state_q, state_d;
  logic [9:0]   fill_h_q, fill_h_d;
  logic [8:0]   fill_v_q, fill_v_d;
  logic [23:0]  fill_color_q, fill_color_d;
  logic         fill_done_q, fill_done_d;
  // 1: the FIFO wins the next contended slot
  logic         prio_fifo_q, prio_fifo_d;

  logic         slot;
  logic         fifo_req;
  logic         fill_req;

  // Round-robin slot arbitration between the CPU FIFO and the fill engine
  always_comb begin
    slot        = !disp_valid;
    fifo_req    = (count_q != '0);
    fill_req    = (state_q == S_FILL);
    grant_fifo  = slot & fifo_req & (!fill_req | prio_fifo_q);
    grant_fill  = slot & fill_req & !grant_fifo;
    prio_fifo_d = prio_fifo_q;
    if (grant_fifo) begin
      prio_fifo_d = 1'b0;
    end else if (grant_fill) begin
      prio_fifo_d = 1'b1;
    end
  end

  // Fill engine: raster-order cursor advanced only on granted slots
  always_comb begin
    state_d      = state_q;
    fill_h_d     = fill_h_q;
    fill_v_d     = fill_v_q;
    fill_color_d = fill_color_q;
    fill_done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          state_d      = S_FILL;
          fill_h_d     = '0;
          fill_v_d     = '0;
          fill_color_d = fill_color;
        end
      end
      S_FILL: begin
        if (grant_fill) begin
          if (fill_h_q == H_LAST) begin
            fill_h_d = '0;
            if (fill_v_q == V_LAST) begin
              state_d     = S_IDLE;
              fill_done_d = 1'b1;
            end else begin
              fill_v_d = fill_v_q + 1'b1;
            end
          end else begin
            fill_h_d = fill_h_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fill engine and arbiter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      fill_h_q     <= '0;
      fill_v_q     <= '0;
      fill_color_q <= '0;
      fill_done_q  <= 1'b0;
      prio_fifo_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      fill_h_q     <= fill_h_d;
      fill_v_q     <= fill_v_d;
      fill_color_q <= fill_color_d;
      fill_done_q  <= fill_done_d;
      prio_fifo_q  <= prio_fifo_d;
    end
  end

  assign fill_addr  = {fill_v_q, fill_h_q};
  assign fill_wdata = fill_color_q;
  assign fill_busy  = (state_q == S_FILL);
  assign fill_done  = fill_done_q;

  logic unused_sig;
  assign unused_sig = disp_v[9];

`else

  assign grant_fifo = !disp_valid & (count_q != '0);
  assign grant_fill = 1'b0;
  assign fill_addr  = '0;
  assign fill_wdata = '0;
  assign fill_busy  = 1'b0;
  assign fill_done  = 1'b0;

  logic unused_sig;
  assign unused_sig = ^{disp_v[9], fill_start, fill_color};

`endif

  // Memory port mux: scan-out address by default, winner's write otherwise
  always_comb begin
    vga_data  = disp_valid ? mem_rdata : '0;
    mem_addr  = {disp_v[8:0], disp_h};
    mem_we    = 1'b0;
    mem_wdata = '0;
    wr_drop   = 1'b0;
    if (grant_fifo) begin
      mem_addr  = {head.v[8:0], head.h};
      mem_wdata = head.data;
      mem_we    = !head_oor;
      wr_drop   = head_oor;
    end else if (grant_fill) begin
      mem_addr  = fill_addr;
      mem_wdata = fill_wdata;
      mem_we    = 1'b1;
    end
  end

endmodule

// File: tb/tb_vmem_sched.sv
// Testbench for vmem_sched: randomized stimulus, queue-based reference
// model, negedge monitor comparing every cycle.
`timescale 1ns/1ps

module tb_vmem_sched;

  localparam int DEPTH = 4;
  localparam int HA    = 8;
  localparam int VA    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        disp_valid = 1'b0;
  logic [9:0]  disp_h = '0;
  logic [9:0]  disp_v = '0;
  logic [23:0] vga_data;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [9:0]  wr_h = '0;
  logic [9:0]  wr_v = '0;
  logic [23:0] wr_data = '0;
  logic        wr_drop;
  logic        fill_start = 1'b0;
  logic [23:0] fill_color = '0;
  logic        fill_busy;
  logic        fill_done;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;

  always #5 clk = ~clk;

  vmem_sched #(
    .FIFO_DEPTH(DEPTH),
    .H_ACTIVE  (HA),
    .V_ACTIVE  (VA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .disp_valid(disp_valid),
    .disp_h    (disp_h),
    .disp_v    (disp_v),
    .vga_data  (vga_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_h      (wr_h),
    .wr_v      (wr_v),
    .wr_data   (wr_data),
    .wr_drop   (wr_drop),
    .fill_start(fill_start),
    .fill_color(fill_color),
    .fill_busy (fill_busy),
    .fill_done (fill_done),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory read data is a fixed function of the address
  function automatic logic [23:0] rd_pat(input logic [18:0] a);
    return {5'd0, a} ^ 24'h5A5A5A;
  endfunction

  assign mem_rdata = rd_pat(mem_addr);

  typedef struct {
    logic [18:0] addr;
    logic [23:0] data;
    bit          drop;
    int          avail;
  } exp_t;

  exp_t cpu_q[$];
  exp_t fill_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  bit   prio_fifo = 1'b1;
  bit   done_due  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: pops expected transactions and compares DUT outputs
  always @(negedge clk) begin : monitor
    int   cnt;
    bit   fifo_req, fill_req, win_fifo, win_fill;
    exp_t e;
    chk("vga_data", vga_data, disp_valid ? rd_pat({disp_v[8:0], disp_h}) : 24'd0);
    if (!rst) begin
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_wr_drop", wr_drop, 0);
      chk("rst_fill_busy", fill_busy, 0);
      chk("rst_fill_done", fill_done, 0);
      cpu_q.delete();
      fill_q.delete();
      prio_fifo = 1'b1;
      done_due  = 1'b0;
    end else begin
      cnt = 0;
      foreach (cpu_q[i]) if (cpu_q[i].avail <= cyc) cnt++;
      fifo_req = (cnt > 0);
      fill_req = (fill_q.size() > 0) && (fill_q[0].avail <= cyc);
      chk("wr_ready", wr_ready, (cnt < DEPTH) ? 1 : 0);
      chk("fill_busy", fill_busy, fill_req ? 1 : 0);
      chk("fill_done", fill_done, done_due ? 1 : 0);
      done_due = 1'b0;
      if (disp_valid) begin
        chk("disp_mem_we", mem_we, 0);
        chk("disp_wr_drop", wr_drop, 0);
        chk("disp_mem_addr", mem_addr, {disp_v[8:0], disp_h});
      end else begin
        win_fifo = fifo_req && (!fill_req || prio_fifo);
        win_fill = fill_req && !win_fifo;
        if (win_fifo) begin
          e = cpu_q.pop_front();
          prio_fifo = 1'b0;
          chk("cpu_mem_we", mem_we, e.drop ? 0 : 1);
          chk("cpu_wr_drop", wr_drop, e.drop ? 1 : 0);
          if (!e.drop) begin
            chk("cpu_mem_addr", mem_addr, e.addr);
            chk("cpu_mem_wdata", mem_wdata, e.data);
          end
        end else if (win_fill) begin
          e = fill_q.pop_front();
          prio_fifo = 1'b1;
          chk("fill_mem_we", mem_we, 1);
          chk("fill_wr_drop", wr_drop, 0);
          chk("fill_mem_addr", mem_addr, e.addr);
          chk("fill_mem_wdata", mem_wdata, e.data);
          if (fill_q.size() == 0) done_due = 1'b1;
        end else begin
          chk("idle_mem_we", mem_we, 0);
          chk("idle_wr_drop", wr_drop, 0);
        end
      end
    end
  end

  // One stimulus cycle; records expected transactions for accepted requests
  task automatic step(input bit disp, input bit wv, input int h, input int v,
                      input logic [23:0] d, input bit fs, input logic [23:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    disp_valid = disp;
    disp_h     = 10'($urandom);
    disp_v     = 10'($urandom);
    wr_valid   = wv;
    wr_h       = 10'(h);
    wr_v       = 10'(v);
    wr_data    = d;
    fill_start = fs;
    fill_color = fc;
    if (wv && wr_ready) begin
      e.addr  = {9'(v), 10'(h)};
      e.data  = d;
      e.drop  = (h >= HA) || (v >= VA);
      e.avail = cyc + 1;
      cpu_q.push_back(e);
    end
`ifdef VMEM_SCHED_FILL_EN
    if (fs && fill_q.size() == 0) begin
      for (int k = 0; k < HA * VA; k++) begin
        e.addr  = {9'(k / HA), 10'(k % HA)};
        e.data  = fc;
        e.drop  = 1'b0;
        e.avail = cyc + 1;
        fill_q.push_back(e);
      end
    end
`endif
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, 24'd0, 1'b0, 24'd0);
  endtask

  task automatic wait_fill(input int limit);
    for (int i = 0; i < limit && fill_q.size() > 0; i++) idle();
    if (fill_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL fill_timeout: got %0d writes left want 0", fill_q.size());
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    wr_valid   = 1'b0;
    fill_start = 1'b0;
    disp_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int h, v;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) idle();

    // single blanking write: h=5, v=3 -> address 0x00C05
    step(1'b0, 1'b1, 5, 3, 24'h00FF00, 1'b0, 24'd0);
    repeat (2) idle();

    // visible region: fill the FIFO, then one refused request
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i, 1, 24'hA00000 + 24'(i), 1'b0, 24'd0);
    repeat (3) step(1'b1, 1'b0, 0, 0, 24'd0, 1'b0, 24'd0);
    repeat (6) idle();

    // range boundaries
    step(1'b0, 1'b1, 640, 0, 24'h111111, 1'b0, 24'd0);
    step(1'b0, 1'b1, HA, 0, 24'h222222, 1'b0, 24'd0);
    step(1'b0, 1'b1, 0, VA, 24'h333333, 1'b0, 24'd0);
    step(1'b0, 1'b1, HA - 1, VA - 1, 24'h444444, 1'b0, 24'd0);
    repeat (4) idle();

    // uncontended fill with an ignored second start
    step(1'b0, 1'b0, 0, 0, 24'd0, 1'b1, 24'h123456);
    repeat (10) idle();
    step(1'b0, 1'b0, 0, 0, 24'd0, 1'b1, 24'hBADBAD);
    wait_fill(200);
    repeat (3) idle();

    // contention between fill and a busy CPU port
    step(1'b0, 1'b1, 1, 1, 24'h0F0F0F, 1'b1, 24'h00AA00);
    for (int i = 0; i < 24; i++)
      step(1'b0, 1'b1, int'($urandom_range(0, HA - 1)), int'($urandom_range(0, VA - 1)),
           24'($urandom), 1'b0, 24'd0);
    wait_fill(300);
    repeat (6) idle();

    // reset in the middle of a fill
    step(1'b0, 1'b1, 2, 2, 24'h555555, 1'b1, 24'h777777);
    repeat (6) idle();
    do_reset(2);
    repeat (4) idle();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      h = int'($urandom_range(0, HA + 1));
      v = int'($urandom_range(0, VA + 1));
      if ($urandom_range(0, 15) == 0) h = 640;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, h, v, 24'($urandom),
           $urandom_range(0, 120) == 0, 24'($urandom));
    end

    // drain everything within a bounded budget
    for (int i = 0; i < 500 && (cpu_q.size() > 0 || fill_q.size() > 0); i++) idle();
    if (cpu_q.size() > 0 || fill_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d/%0d left want 0/0", cpu_q.size(), fill_q.size());
    end
    repeat (3) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
